// File: rtl/alien_sprite_pipeline.sv
// Two-stage alien sprite renderer: per-slot range test against a frame-stable
// shadow table, then fixed-priority select and ROM address generation.
module alien_sprite_pipeline #(
    parameter int N_OBJ  = 4,
    parameter int HALF   = 32,
    parameter int R_W    = 6,
    parameter int ADDR_W = 16,
    localparam int ID_W  = (N_OBJ > 1) ? $clog2(N_OBJ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [9:0]            h_cnt,
    input  logic [9:0]            v_cnt,
    input  logic                  pix_valid,
    input  logic                  frame_start,
    input  logic [N_OBJ-1:0]      obj_en,
    input  logic [N_OBJ*10-1:0]   obj_x,
    input  logic [N_OBJ*10-1:0]   obj_y,
    input  logic [N_OBJ*R_W-1:0]  obj_r,
    input  logic [N_OBJ*2-1:0]    obj_deriv_left,
    input  logic [N_OBJ*2-1:0]    obj_deriv_right,
    output logic                  out_valid,
    output logic                  hit,
    output logic [ID_W-1:0]       obj_id,
    output logic [1:0]            deriv_select,
    output logic [ADDR_W-1:0]     pixel_addr
);

    localparam int HSW = R_W + 1;

    logic [N_OBJ-1:0]     sh_en;
    logic [N_OBJ*10-1:0]  sh_x;
    logic [N_OBJ*10-1:0]  sh_y;
    logic [N_OBJ*R_W-1:0] sh_r;
    logic [N_OBJ*2-1:0]   sh_dl;
    logic [N_OBJ*2-1:0]   sh_dr;

    // The pipeline reads only the shadow copy, so a pixel launched in the
    // frame_start cycle still sees the old table.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_en <= '0;
            sh_x  <= '0;
            sh_y  <= '0;
            sh_r  <= '0;
            sh_dl <= '0;
            sh_dr <= '0;
        end else if (frame_start) begin
            sh_en <= obj_en;
            sh_x  <= obj_x;
            sh_y  <= obj_y;
            sh_r  <= obj_r;
            sh_dl <= obj_deriv_left;
            sh_dr <= obj_deriv_right;
        end
    end

    logic [N_OBJ-1:0] n1_in;
    logic [11:0]      n1_c  [N_OBJ];
    logic [11:0]      n1_dy [N_OBJ];
    logic [HSW-1:0]   n1_hs [N_OBJ];
    logic [1:0]       n1_d  [N_OBJ];

    for (genvar i = 0; i < N_OBJ; i++) begin : g_slot
        logic signed [HSW-1:0] hs_n;
        logic signed [11:0]    hs_w;
        logic signed [11:0]    dx;
        logic signed [11:0]    dy;

        assign hs_n = HSW'(HALF) - HSW'(sh_r[i*R_W +: R_W]);
        assign hs_w = 12'(hs_n);
        assign dx   = $signed({2'b00, h_cnt}) - $signed({2'b00, sh_x[i*10 +: 10]});
        assign dy   = $signed({2'b00, v_cnt}) - ($signed({2'b00, sh_y[i*10 +: 10]}) - hs_w);

        assign n1_in[i] = sh_en[i] && (hs_w > 12'sd0)
                          && (dx >= -hs_w) && (dx < hs_w)
                          && (dy >= 12'sd0) && (dy < (hs_w <<< 1));
        // Left half is mirrored so the centre column is not drawn twice.
        assign n1_c[i]  = dx[11] ? 12'(-dx - 12'sd1) : 12'(dx);
        assign n1_dy[i] = 12'(dy);
        assign n1_hs[i] = hs_n;
        assign n1_d[i]  = dx[11] ? sh_dl[i*2 +: 2] : sh_dr[i*2 +: 2];
    end

    logic             s1_valid;
    logic [N_OBJ-1:0] s1_in;
    logic [11:0]      s1_c  [N_OBJ];
    logic [11:0]      s1_dy [N_OBJ];
    logic [HSW-1:0]   s1_hs [N_OBJ];
    logic [1:0]       s1_d  [N_OBJ];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_in    <= '0;
            for (int i = 0; i < N_OBJ; i++) begin
                s1_c[i]  <= '0;
                s1_dy[i] <= '0;
                s1_hs[i] <= '0;
                s1_d[i]  <= '0;
            end
        end else begin
            s1_valid <= pix_valid;
            s1_in    <= n1_in;
            for (int i = 0; i < N_OBJ; i++) begin
                s1_c[i]  <= n1_c[i];
                s1_dy[i] <= n1_dy[i];
                s1_hs[i] <= n1_hs[i];
                s1_d[i]  <= n1_d[i];
            end
        end
    end

    logic              w_found;
    logic [ID_W-1:0]   w_id;
    logic [11:0]       w_c;
    logic [11:0]       w_dy;
    logic [HSW-1:0]    w_hs;
    logic [1:0]        w_d;
    logic [ADDR_W-1:0] w_addr;

    // Scanning downward lets the lowest-index in-range slot win.
    always_comb begin
        w_found = 1'b0;
        w_id    = '0;
        w_c     = '0;
        w_dy    = '0;
        w_hs    = '0;
        w_d     = '0;
        for (int i = N_OBJ - 1; i >= 0; i--) begin
            if (s1_in[i]) begin
                w_found = 1'b1;
                w_id    = ID_W'(i);
                w_c     = s1_c[i];
                w_dy    = s1_dy[i];
                w_hs    = s1_hs[i];
                w_d     = s1_d[i];
            end
        end
        w_addr = ADDR_W'(w_dy) * ADDR_W'(w_hs) + ADDR_W'(w_c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            hit          <= 1'b0;
            obj_id       <= '0;
            deriv_select <= '0;
            pixel_addr   <= '0;
        end else begin
            out_valid    <= s1_valid;
            hit          <= w_found;
            obj_id       <= w_id;
            deriv_select <= w_d;
            pixel_addr   <= w_addr;
        end
    end

endmodule

// File: tb/tb_alien_sprite_pipeline.sv
// Directed bench for alien_sprite_pipeline: hand-computed pixel results,
// shadow-table behaviour, valid-pipeline pattern and mid-stream reset.
module tb_alien_sprite_pipeline;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  h_cnt, v_cnt;
    logic        pix_valid, frame_start;
    logic [3:0]  obj_en;
    logic [39:0] obj_x, obj_y;
    logic [23:0] obj_r;
    logic [7:0]  obj_deriv_left, obj_deriv_right;
    logic        out_valid, hit;
    logic [1:0]  obj_id, deriv_select;
    logic [15:0] pixel_addr;

    int n_assert = 0;
    int n_fail   = 0;

    alien_sprite_pipeline #(.N_OBJ(4), .HALF(32), .R_W(6), .ADDR_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .h_cnt(h_cnt), .v_cnt(v_cnt),
        .pix_valid(pix_valid), .frame_start(frame_start), .obj_en(obj_en),
        .obj_x(obj_x), .obj_y(obj_y), .obj_r(obj_r),
        .obj_deriv_left(obj_deriv_left), .obj_deriv_right(obj_deriv_right),
        .out_valid(out_valid), .hit(hit), .obj_id(obj_id),
        .deriv_select(deriv_select), .pixel_addr(pixel_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_obj(input int idx, input logic en, input logic [9:0] x, input logic [9:0] y,
                           input logic [5:0] r, input logic [1:0] dl, input logic [1:0] dr);
        obj_en[idx]                 = en;
        obj_x[idx*10 +: 10]         = x;
        obj_y[idx*10 +: 10]         = y;
        obj_r[idx*6 +: 6]           = r;
        obj_deriv_left[idx*2 +: 2]  = dl;
        obj_deriv_right[idx*2 +: 2] = dr;
    endtask

    task automatic load_frame();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic e_hit, input logic [1:0] e_id,
                             input logic [1:0] e_d, input logic [15:0] e_addr);
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".hit"},   32'(hit), 32'(e_hit));
        check({tag, ".id"},    32'(obj_id), 32'(e_id));
        check({tag, ".deriv"}, 32'(deriv_select), 32'(e_d));
        check({tag, ".addr"},  32'(pixel_addr), 32'(e_addr));
    endtask

    // Launch one pixel and check the result two clock edges later.
    task automatic pix(input string tag, input logic [9:0] h, input logic [9:0] v,
                       input logic e_hit, input logic [1:0] e_id,
                       input logic [1:0] e_d, input logic [15:0] e_addr);
        @(negedge clk);
        h_cnt = h; v_cnt = v; pix_valid = 1'b1;
        @(negedge clk);
        pix_valid = 1'b0;
        @(negedge clk);
        check_out(tag, e_hit, e_id, e_d, e_addr);
    endtask

    logic [63:0] pat;
    logic        exp_v;

    initial begin
        rst_n = 1'b0;
        h_cnt = '0; v_cnt = '0; pix_valid = 1'b0; frame_start = 1'b0;
        obj_en = '0; obj_x = '0; obj_y = '0; obj_r = '0;
        obj_deriv_left = '0; obj_deriv_right = '0;
        repeat (3) @(negedge clk);
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.hit",   32'(hit), 32'd0);
        check("rst.id",    32'(obj_id), 32'd0);
        check("rst.deriv", 32'(deriv_select), 32'd0);
        check("rst.addr",  32'(pixel_addr), 32'd0);
        rst_n = 1'b1;

        // Single object, right half and mirrored left half
        set_obj(0, 1'b1, 10'd100, 10'd100, 6'd0, 2'd1, 2'd2);
        load_frame();
        pix("right",    10'd110, 10'd80, 1'b1, 2'd0, 2'd2, 16'd394);
        pix("mirror",   10'd99,  10'd80, 1'b1, 2'd0, 2'd1, 16'd384);
        pix("leftedge", 10'd68,  10'd68, 1'b1, 2'd0, 2'd1, 16'd31);
        pix("rightout", 10'd132, 10'd68, 1'b0, 2'd0, 2'd0, 16'd0);

        // Depth and disable
        set_obj(0, 1'b1, 10'd100, 10'd100, 6'd16, 2'd1, 2'd2);
        load_frame();
        pix("r16",      10'd115, 10'd99, 1'b1, 2'd0, 2'd2, 16'd255);
        set_obj(0, 1'b1, 10'd100, 10'd100, 6'd32, 2'd1, 2'd2);
        load_frame();
        pix("r32",      10'd100, 10'd100, 1'b0, 2'd0, 2'd0, 16'd0);
        set_obj(0, 1'b0, 10'd100, 10'd100, 6'd0, 2'd1, 2'd2);
        load_frame();
        pix("disabled", 10'd110, 10'd80, 1'b0, 2'd0, 2'd0, 16'd0);

        // Priority between overlapping slots 1 and 3
        set_obj(1, 1'b1, 10'd200, 10'd200, 6'd0,  2'd0, 2'd3);
        set_obj(3, 1'b1, 10'd200, 10'd200, 6'd16, 2'd3, 2'd1);
        load_frame();
        pix("prio1",    10'd200, 10'd200, 1'b1, 2'd1, 2'd3, 16'd1024);
        set_obj(1, 1'b0, 10'd200, 10'd200, 6'd0,  2'd0, 2'd3);
        load_frame();
        pix("prio3",    10'd200, 10'd200, 1'b1, 2'd3, 2'd1, 16'd256);

        // Underflow near the top edge
        set_obj(3, 1'b0, 10'd200, 10'd200, 6'd16, 2'd3, 2'd1);
        set_obj(0, 1'b1, 10'd100, 10'd10, 6'd0, 2'd1, 2'd2);
        load_frame();
        pix("top.r",    10'd100, 10'd0, 1'b1, 2'd0, 2'd2, 16'd704);
        pix("top.l",    10'd99,  10'd0, 1'b1, 2'd0, 2'd1, 16'd704);

        // Shadow table: live change ignored until frame_start
        set_obj(0, 1'b1, 10'd100, 10'd100, 6'd0, 2'd1, 2'd2);
        load_frame();
        set_obj(0, 1'b1, 10'd300, 10'd100, 6'd0, 2'd1, 2'd2);
        pix("shadow",   10'd110, 10'd80, 1'b1, 2'd0, 2'd2, 16'd394);
        @(negedge clk);
        frame_start = 1'b1; h_cnt = 10'd110; v_cnt = 10'd80; pix_valid = 1'b1;
        @(negedge clk);
        frame_start = 1'b0; pix_valid = 1'b0;
        @(negedge clk);
        check_out("fs_same", 1'b1, 2'd0, 2'd2, 16'd394);
        pix("newtab",   10'd310, 10'd80, 1'b1, 2'd0, 2'd2, 16'd394);
        pix("oldpos",   10'd110, 10'd80, 1'b0, 2'd0, 2'd0, 16'd0);

        // Valid pattern through the pipeline with gaps
        pat = 64'hA5F0_3C96_0FF1_8E27;
        h_cnt = 10'd310; v_cnt = 10'd80;
        for (int k = 0; k < 66; k++) begin
            @(negedge clk);
            exp_v = (k >= 2) ? pat[k-2] : 1'b0;
            check($sformatf("stream%0d", k), 32'(out_valid), 32'(exp_v));
            pix_valid = (k < 64) ? pat[k] : 1'b0;
        end

        // Reset mid-stream
        @(negedge clk);
        pix_valid = 1'b1;
        repeat (2) @(negedge clk);
        check("prerst.hit", 32'(hit), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst.valid", 32'(out_valid), 32'd0);
        check("midrst.hit",   32'(hit), 32'd0);
        check("midrst.id",    32'(obj_id), 32'd0);
        check("midrst.deriv", 32'(deriv_select), 32'd0);
        check("midrst.addr",  32'(pixel_addr), 32'd0);
        pix_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        pix("postrst",  10'd310, 10'd80, 1'b0, 2'd0, 2'd0, 16'd0);
        load_frame();
        pix("reload",   10'd310, 10'd80, 1'b1, 2'd0, 2'd2, 16'd394);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
